// File: rtl/sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sensor_conditioner: 2-flop synchronisers, per-bit debouncers and a        |
// | temperature stability filter. TEMP_HYST_EN adds 2-LSB accept hysteresis.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int TEMP_STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SFD_raw,
  input  logic       SRD_raw,
  input  logic       SFA_raw,
  input  logic       SW_raw,
  input  logic       ST_raw,
  input  logic [5:0] temperature_raw,
  output logic       SFD,
  output logic       SRD,
  output logic       SFA,
  output logic       SW,
  output logic       ST,
  output logic [5:0] temperature,
  output logic       temp_valid,
  output logic       sensor_event
);

  localparam int         c_nsens    = 5;
  localparam logic [3:0] c_deb_last = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] c_tmp_last = 4'(TEMP_STABLE_CYCLES - 1);

  logic [10:0] r_meta;
  logic [10:0] r_sync;
  logic [4:0]  w_sens_sync;
  logic [5:0]  w_temp_sync;
  logic [4:0]  w_sens_out;
  logic [4:0]  w_sens_flip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw, temperature_raw};
      r_sync <= r_meta;
    end
  end

  assign w_sens_sync = r_sync[10:6];
  assign w_temp_sync = r_sync[5:0];

  generate
    for (genvar gi = 0; gi < c_nsens; gi++) begin : g_deb
      logic [3:0] r_cnt;
      logic       r_out;
      logic       w_diff;

      assign w_diff          = (w_sens_sync[gi] != r_out);
      assign w_sens_flip[gi] = w_diff && (r_cnt == c_deb_last);
      assign w_sens_out[gi]  = r_out;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_out <= 1'b0;
        end else if (w_sens_flip[gi]) begin
          r_cnt <= '0;
          r_out <= w_sens_sync[gi];
        end else if (w_diff) begin
          r_cnt <= r_cnt + 4'd1;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

  logic [5:0] r_cand;
  logic [3:0] r_tcnt;
  logic [5:0] r_temp;
  logic       r_valid;
  logic       r_event;
  logic       w_stable;
  logic       w_accept;
  logic       w_temp_upd;

  // Acceptance is re-evaluated every cycle while the counter is saturated.
  assign w_stable = (w_temp_sync == r_cand) && (r_tcnt == c_tmp_last);

`ifdef TEMP_HYST_EN
  logic [6:0] w_tdiff;
  assign w_tdiff  = (r_cand >= r_temp) ? ({1'b0, r_cand} - {1'b0, r_temp})
                                       : ({1'b0, r_temp} - {1'b0, r_cand});
  assign w_accept = w_stable && (!r_valid || (w_tdiff >= 7'd2));
`else
  assign w_accept = w_stable && (!r_valid || (r_cand != r_temp));
`endif

  assign w_temp_upd = w_accept && (r_cand != r_temp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand  <= '0;
      r_tcnt  <= '0;
      r_temp  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_temp_sync != r_cand) begin
        r_cand <= w_temp_sync;
        r_tcnt <= '0;
      end else if (r_tcnt != c_tmp_last) begin
        r_tcnt <= r_tcnt + 4'd1;
      end
      if (w_accept) begin
        r_temp  <= r_cand;
        r_valid <= 1'b1;
      end
    end
  end

  // A first acceptance of an unchanged value raises temp_valid silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_event <= 1'b0;
    end else begin
      r_event <= (|w_sens_flip) || w_temp_upd;
    end
  end

  assign {SFD, SRD, SFA, SW, ST} = w_sens_out;
  assign temperature             = r_temp;
  assign temp_valid              = r_valid;
  assign sensor_event            = r_event;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sensor_conditioner: directed and random stimulus against a sample-    |
// | window reference model. Revision: 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_sensor_conditioner;

  localparam int DEB = 4;
  localparam int TS  = 4;
`ifdef TEMP_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw;
  logic [5:0] temperature_raw;
  logic       SFD, SRD, SFA, SW, ST;
  logic [5:0] temperature;
  logic       temp_valid;
  logic       sensor_event;

  int n_pass  = 0;
  int n_total = 0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .TEMP_STABLE_CYCLES(TS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .SFD_raw        (SFD_raw),
    .SRD_raw        (SRD_raw),
    .SFA_raw        (SFA_raw),
    .SW_raw         (SW_raw),
    .ST_raw         (ST_raw),
    .temperature_raw(temperature_raw),
    .SFD            (SFD),
    .SRD            (SRD),
    .SFA            (SFA),
    .SW             (SW),
    .ST             (ST),
    .temperature    (temperature),
    .temp_valid     (temp_valid),
    .sensor_event   (sensor_event)
  );

  always #5 clk = ~clk;

  // Reference model: outputs derived from windows of synchronised samples.
  logic [10:0] rawq[$];
  logic [4:0]  hs[$];
  logic [5:0]  tq[$];
  logic [4:0]  m_sens;
  logic [5:0]  m_temp;
  logic        m_valid;
  logic        m_event;

  function automatic logic [13:0] obs();
    return {SFD, SRD, SFA, SW, ST, temperature, temp_valid, sensor_event};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    rawq    = '{11'd0, 11'd0};
    hs.delete();
    tq      = '{6'd0};
    m_sens  = '0;
    m_temp  = '0;
    m_valid = 1'b0;
    m_event = 1'b0;
  endtask

  task automatic model_step(input logic [10:0] raw);
    logic [10:0] h;
    logic [4:0]  ns;
    logic [5:0]  nt;
    logic        nv;
    logic [5:0]  c;
    bit          flip;
    bit          same;
    bit          ok;
    int          d;
    rawq.push_back(raw);
    h = rawq[rawq.size() - 3];
    if (rawq.size() > 4) void'(rawq.pop_front());
    hs.push_back(h[10:6]);
    if (hs.size() > DEB) void'(hs.pop_front());
    tq.push_back(h[5:0]);
    if (tq.size() > TS + 1) void'(tq.pop_front());
    ns = m_sens;
    if (hs.size() == DEB) begin
      for (int b = 0; b < 5; b++) begin
        flip = 1'b1;
        foreach (hs[k]) if (hs[k][b] == m_sens[b]) flip = 1'b0;
        if (flip) ns[b] = ~m_sens[b];
      end
    end
    nt = m_temp;
    nv = m_valid;
    if (tq.size() == TS + 1) begin
      c    = tq[0];
      same = 1'b1;
      foreach (tq[k]) if (tq[k] != c) same = 1'b0;
      d = int'(c) - int'(m_temp);
      if (d < 0) d = -d;
      ok = HYST ? (d >= 2) : (d != 0);
      if (same && (!m_valid || ok)) begin
        nt = c;
        nv = 1'b1;
      end
    end
    m_event = (ns != m_sens) || (nt != m_temp);
    m_sens  = ns;
    m_temp  = nt;
    m_valid = nv;
  endtask

  task automatic tick();
    logic [10:0] raw;
    raw = {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw, temperature_raw};
    @(posedge clk);
    if (reset) model_reset();
    else model_step(raw);
    #1;
    chk("cycle", obs(), {m_sens, m_temp, m_valid, m_event});
  endtask

  int          ev;
  logic        seen;
  int          hold;
  logic [4:0]  sv;

  initial begin
    reset = 1'b1;
    {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw} = '0;
    temperature_raw = '0;
    model_reset();
    #1;
    chk("reset_state", obs(), 14'd0);
    tick();
    tick();
    reset = 1'b0;

    // Async reset in the middle of a debounce, then a clean rise.
    SFD_raw = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_mid_debounce", obs(), 14'd0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 4) chk("first_accept_zero_no_event", {temp_valid, sensor_event, temperature}, 8'b1000_0000);
      if (i == 5) chk("sfd_not_early", SFD, 1'b0);
      if (i == 6) chk("sfd_rise_edge6", {SFD, sensor_event}, 2'b11);
      if (i == 7) chk("sfd_event_one_cycle", sensor_event, 1'b0);
    end

    // Glitch of 3 cycles suppressed, 4 cycles passes.
    seen = 1'b0;
    ev   = 0;
    for (int i = 0; i < 13; i++) begin
      SW_raw = (i < 3);
      tick();
      seen |= SW;
      ev += int'(sensor_event);
    end
    chk("glitch3_sw", seen, 1'b0);
    chk("glitch3_event", ev, 0);
    seen = 1'b0;
    ev   = 0;
    for (int i = 0; i < 14; i++) begin
      SW_raw = (i < 4);
      tick();
      seen |= SW;
      ev += int'(sensor_event);
    end
    chk("glitch4_sw", seen, 1'b1);
    chk("glitch4_events", ev, 2);

    // Temperature acceptance latency and dither rejection.
    {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw} = '0;
    temperature_raw = 6'd30;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) chk("temp_not_early", {temp_valid, temperature}, 7'd0);
      if (i == 7) chk("temp_accept_edge7", {temp_valid, temperature, sensor_event}, {1'b1, 6'd30, 1'b1});
    end
    ev = 0;
    for (int i = 0; i < 12; i++) begin
      temperature_raw = (i < 2) ? 6'd31 : 6'd30;
      tick();
      ev += int'(sensor_event);
    end
    chk("short31_temp", temperature, 6'd30);
    chk("short31_event", ev, 0);

    // Simultaneous sensor changes.
    SFA_raw = 1'b1;
    ST_raw  = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) chk("simul_not_early", {SFA, ST}, 2'b00);
      if (i == 6) chk("simul_rise", {SFA, ST, sensor_event}, 3'b111);
      if (i == 7) chk("simul_single_pulse", sensor_event, 1'b0);
    end

    // Steady 31: accepted unless hysteresis is enabled.
    temperature_raw = 6'd31;
    repeat (10) tick();
    chk("steady31", temperature, HYST ? 6'd30 : 6'd31);

    // Skewed 31 -> 32 transition.
    seen = 1'b0;
    ev   = 0;
    temperature_raw = 6'd63;
    tick();
    seen |= (temperature == 6'd63) || (temperature == 6'd35);
    temperature_raw = 6'd35;
    tick();
    seen |= (temperature == 6'd63) || (temperature == 6'd35);
    ev += int'(sensor_event);
    temperature_raw = 6'd32;
    for (int i = 1; i <= 12; i++) begin
      tick();
      seen |= (temperature == 6'd63) || (temperature == 6'd35);
      ev += int'(sensor_event);
      if (i == 6) chk("skew_not_early", temperature == 6'd32, 1'b0);
      if (i == 7) chk("skew_accept_edge7", {temperature, sensor_event}, {6'd32, 1'b1});
    end
    chk("skew_no_mixed_code", seen, 1'b0);
    chk("skew_one_event", ev, 1);

    // Random stimulus against the model, with one reset in the middle.
    hold = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      sv = {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw};
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 5) == 0) sv[b] = ~sv[b];
      {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw} = sv;
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    temperature_raw = 6'($urandom_range(0, 63));
          2:       temperature_raw = ($urandom_range(0, 1) == 1) ? temperature_raw + 6'd1 : temperature_raw - 6'd1;
          default: temperature_raw = temperature_raw ^ 6'($urandom_range(1, 7));
        endcase
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      reset = (cyc == 400) || (cyc == 401);
      tick();
    end
    reset = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
